fsm_rx: RTL and testbench

FSM_RX -- requirements
Module: fsm_rx

---
 rtl/fsm_rx.sv | 247 ++++++++++++++++++++++++
 tb/tb_fsm_rx.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_rx.sv
`default_nettype none
// ============================================================================
// Module      : fsm_rx
// Description : Oversampled asynchronous serial receiver. It synchronises the
//               line, detects start edges and takes a majority vote around mid-bit.
//               It captures LSB-first data with optional even/odd parity and a
//               single stop bit. It reports receive-complete, frame, parity and
//               overrun status.
// Revision    : 1.0 - initial release
// ============================================================================
module fsm_rx #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 i_rxclk,
    input  logic                 i_rst_n,
    input  logic                 i_rxd,
    input  logic                 i_rxen,
    input  logic                 i_upm1,
    input  logic                 i_upm0,
    input  logic                 i_udr_read,
    output logic [DATA_BITS-1:0] o_udr_data,
    output logic                 o_rxc,
    output logic                 o_fe,
    output logic                 o_pe,
    output logic                 o_dor,
    output logic                 o_busy
);

    localparam int c_CW = $clog2(OVERSAMPLE);
    localparam int c_BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(OVERSAMPLE - 1);
    localparam logic [c_CW-1:0] c_CNT_MM1  = c_CW'(OVERSAMPLE / 2 - 1);
    localparam logic [c_CW-1:0] c_CNT_MID  = c_CW'(OVERSAMPLE / 2);
    localparam logic [c_CW-1:0] c_CNT_MP1  = c_CW'(OVERSAMPLE / 2 + 1);
    localparam logic [c_BW-1:0] c_BIT_LAST = c_BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        START_BIT    = 3'd1,
        RECEIVE_DATA = 3'd2,
        PARITY_CHECK = 3'd3,
        STOP_BIT     = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_next;

    logic                   r_sync1;
    logic                   r_rxd_s;
    logic                   r_rxd_prev;
    // Marks which of sync1 / rxd_s / rxd_prev hold real line samples since
    // reset release, so the reset value of 1 cannot fake a falling edge.
    logic [2:0]             r_vld;

    logic [c_CW-1:0]        r_cnt;
    logic [c_BW-1:0]        r_bit;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_s_m1;
    logic                   r_s_m;
    logic                   r_upm1;
    logic                   r_upm0;
    logic                   r_perr;

    logic [DATA_BITS-1:0]   r_udr_data;
    logic                   r_rxc;
    logic                   r_fe;
    logic                   r_pe;
    logic                   r_dor;

    logic                   w_fall;
    logic                   w_maj;
    logic                   w_at_mp1;
    logic                   w_at_last;
    logic                   w_start;
    logic                   w_shift_en;
    logic                   w_par_en;
    logic                   w_complete;

    assign w_fall    = r_vld[2] & r_rxd_prev & ~r_rxd_s;
    assign w_maj     = (r_s_m1 & r_s_m) | (r_s_m1 & r_rxd_s) | (r_s_m & r_rxd_s);
    assign w_at_mp1  = (r_cnt == c_CNT_MP1);
    assign w_at_last = (r_cnt == c_CNT_LAST);

    // Two-flop line synchroniser plus previous-sample register for edge detect.
    always_ff @(posedge i_rxclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1    <= 1'b1;
            r_rxd_s    <= 1'b1;
            r_rxd_prev <= 1'b1;
            r_vld      <= 3'b000;
        end else begin
            r_sync1    <= i_rxd;
            r_rxd_s    <= r_sync1;
            r_rxd_prev <= r_rxd_s;
            r_vld      <= {r_vld[1:0], 1'b1};
        end
    end

    // State register.
    always_ff @(posedge i_rxclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and per-cycle datapath strobes.
    always_comb begin
        w_next     = r_state;
        w_start    = 1'b0;
        w_shift_en = 1'b0;
        w_par_en   = 1'b0;
        w_complete = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_fall) begin
                    w_next  = START_BIT;
                    w_start = 1'b1;
                end
            end
            START_BIT: begin
                if (w_at_mp1 && w_maj) begin
                    w_next = IDLE;
                end else if (w_at_last) begin
                    w_next = RECEIVE_DATA;
                end
            end
            RECEIVE_DATA: begin
                w_shift_en = w_at_mp1;
                if (w_at_last && (r_bit == c_BIT_LAST)) begin
                    w_next = r_upm1 ? PARITY_CHECK : STOP_BIT;
                end
            end
            PARITY_CHECK: begin
                w_par_en = w_at_mp1;
                if (w_at_last) begin
                    w_next = STOP_BIT;
                end
            end
            STOP_BIT: begin
                if (w_at_mp1) begin
                    w_complete = 1'b1;
                    w_next     = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
        // Disabling the receiver drops any frame in flight.
        if (!i_rxen) begin
            w_next     = IDLE;
            w_start    = 1'b0;
            w_shift_en = 1'b0;
            w_par_en   = 1'b0;
            w_complete = 1'b0;
        end
    end

    // Oversample counter: held at 0 in IDLE, wraps every bit period otherwise.
    always_ff @(posedge i_rxclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if ((r_state == IDLE) || (w_next == IDLE) || w_at_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Data bit index, advanced at the end of each data bit period.
    always_ff @(posedge i_rxclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bit <= '0;
        end else if ((r_state != RECEIVE_DATA) || (w_next != RECEIVE_DATA)) begin
            r_bit <= '0;
        end else if (w_at_last) begin
            r_bit <= r_bit + 1'b1;
        end
    end

    // Capture the two early majority samples; the third is the live rxd_s.
    always_ff @(posedge i_rxclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s_m1 <= 1'b1;
            r_s_m  <= 1'b1;
        end else if (r_state != IDLE) begin
            if (r_cnt == c_CNT_MM1) r_s_m1 <= r_rxd_s;
            if (r_cnt == c_CNT_MID) r_s_m  <= r_rxd_s;
        end
    end

    // Frame datapath: parity mode latch, data shift register, parity result.
    always_ff @(posedge i_rxclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_upm1  <= 1'b0;
            r_upm0  <= 1'b0;
            r_shift <= '0;
            r_perr  <= 1'b0;
        end else begin
            if (w_start) begin
                r_upm1 <= i_upm1;
                r_upm0 <= i_upm0;
            end
            if (w_shift_en) begin
                r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
            end
            if (w_par_en) begin
                r_perr <= ((^r_shift) ^ w_maj) != r_upm0;
            end
        end
    end

    // Consumer-visible data and status registers.
    always_ff @(posedge i_rxclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_udr_data <= '0;
            r_rxc      <= 1'b0;
            r_fe       <= 1'b0;
            r_pe       <= 1'b0;
            r_dor      <= 1'b0;
        end else if (w_complete) begin
            if (!r_rxc || i_udr_read) begin
                r_udr_data <= r_shift;
                r_fe       <= ~w_maj;
                r_pe       <= r_upm1 & r_perr;
                r_rxc      <= 1'b1;
                r_dor      <= 1'b0;
            end else begin
                r_dor      <= 1'b1;
            end
        end else if (i_udr_read) begin
            r_rxc <= 1'b0;
            r_dor <= 1'b0;
        end
    end

    assign o_udr_data = r_udr_data;
    assign o_rxc      = r_rxc;
    assign o_fe       = r_fe;
    assign o_pe       = r_pe;
    assign o_dor      = r_dor;
    assign o_busy     = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fsm_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_fsm_rx
// Description : Directed self-checking bench for fsm_rx (OVERSAMPLE=16,
//               DATA_BITS=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fsm_rx;

    localparam int c_OS = 16;

    logic       i_rxclk    = 1'b0;
    logic       i_rst_n    = 1'b0;
    logic       i_rxd      = 1'b1;
    logic       i_rxen     = 1'b1;
    logic       i_upm1     = 1'b0;
    logic       i_upm0     = 1'b0;
    logic       i_udr_read = 1'b0;
    logic [7:0] o_udr_data;
    logic       o_rxc;
    logic       o_fe;
    logic       o_pe;
    logic       o_dor;
    logic       o_busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 i_rxclk = ~i_rxclk;

    fsm_rx #(
        .OVERSAMPLE (16),
        .DATA_BITS  (8)
    ) u_dut (
        .i_rxclk    (i_rxclk),
        .i_rst_n    (i_rst_n),
        .i_rxd      (i_rxd),
        .i_rxen     (i_rxen),
        .i_upm1     (i_upm1),
        .i_upm0     (i_upm0),
        .i_udr_read (i_udr_read),
        .o_udr_data (o_udr_data),
        .o_rxc      (o_rxc),
        .o_fe       (o_fe),
        .o_pe       (o_pe),
        .o_dor      (o_dor),
        .o_busy     (o_busy)
    );

    // Count one comparison and report it if observed differs from expected.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge i_rxclk);
    endtask

    // Drive n line bits LSB first, one bit period each.
    task automatic send_bits(input logic [15:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            i_rxd = v[i];
            wait_cycles(c_OS);
        end
    endtask

    // Full frame followed by one idle bit period.
    task automatic send_frame(input logic [7:0] d, input logic par_en,
                              input logic par, input logic stop);
        if (par_en) send_bits({5'b0, stop, par, d, 1'b0}, 11);
        else        send_bits({6'b0, stop, d, 1'b0}, 10);
        i_rxd = 1'b1;
        wait_cycles(c_OS);
    endtask

    task automatic read_pulse();
        @(negedge i_rxclk);
        i_udr_read = 1'b1;
        @(negedge i_rxclk);
        i_udr_read = 1'b0;
    endtask

    initial begin : main
        int  rise;
        logic seen_busy;

        // Reset state
        wait_cycles(4);
        check("rst_data", 32'(o_udr_data), 32'h00);
        check("rst_rxc",  32'(o_rxc),  32'd0);
        check("rst_fe",   32'(o_fe),   32'd0);
        check("rst_pe",   32'(o_pe),   32'd0);
        check("rst_dor",  32'(o_dor),  32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        i_rst_n = 1'b1;
        wait_cycles(8);

        // 0xA5, no parity, measure rxc rise into the stop bit
        i_upm1 = 1'b0;
        send_bits({7'b0, 8'hA5, 1'b0}, 9);
        check("a5_rxc_before_stop", 32'(o_rxc), 32'd0);
        i_rxd = 1'b1;
        rise  = -1;
        for (int k = 1; k <= c_OS; k++) begin
            @(negedge i_rxclk);
            if (rise < 0 && o_rxc) rise = k;
        end
        // Mid-bit vote (~9) plus synchroniser and edge-detect latency.
        check("a5_rise_window", 32'((rise >= 10) && (rise <= 14)), 32'd1);
        check("a5_data", 32'(o_udr_data), 32'hA5);
        check("a5_fe",   32'(o_fe),  32'd0);
        check("a5_pe",   32'(o_pe),  32'd0);
        check("a5_dor",  32'(o_dor), 32'd0);
        read_pulse();
        check("a5_read_rxc",  32'(o_rxc), 32'd0);
        check("a5_read_data", 32'(o_udr_data), 32'hA5);

        // Even parity: 0x3C has four ones
        i_upm1 = 1'b1;
        i_upm0 = 1'b0;
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
        check("3c_even_p1_data", 32'(o_udr_data), 32'h3C);
        check("3c_even_p1_pe",   32'(o_pe), 32'd1);
        check("3c_even_p1_fe",   32'(o_fe), 32'd0);
        read_pulse();
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
        check("3c_even_p0_data", 32'(o_udr_data), 32'h3C);
        check("3c_even_p0_pe",   32'(o_pe), 32'd0);
        read_pulse();
        i_upm0 = 1'b1;
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
        check("3c_odd_p1_pe",  32'(o_pe),  32'd0);
        check("3c_odd_p1_rxc", 32'(o_rxc), 32'd1);

        // Short low glitch: false start with flags untouched
        i_upm1    = 1'b0;
        i_upm0    = 1'b0;
        seen_busy = 1'b0;
        i_rxd     = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge i_rxclk);
            seen_busy |= o_busy;
        end
        i_rxd = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge i_rxclk);
            seen_busy |= o_busy;
        end
        check("glitch_busy_pulse", 32'(seen_busy), 32'd1);
        check("glitch_busy_end",   32'(o_busy), 32'd0);
        check("glitch_rxc",  32'(o_rxc), 32'd1);
        check("glitch_data", 32'(o_udr_data), 32'h3C);
        check("glitch_fe",   32'(o_fe), 32'd0);
        check("glitch_pe",   32'(o_pe), 32'd0);
        read_pulse();
        check("glitch_read_rxc", 32'(o_rxc), 32'd0);

        // Framing error, then recovery
        send_frame(8'h55, 1'b0, 1'b0, 1'b0);
        check("55_fe",   32'(o_fe),  32'd1);
        check("55_rxc",  32'(o_rxc), 32'd1);
        check("55_data", 32'(o_udr_data), 32'h55);
        read_pulse();
        send_frame(8'h12, 1'b0, 1'b0, 1'b1);
        check("12_data", 32'(o_udr_data), 32'h12);
        check("12_fe",   32'(o_fe),  32'd0);
        check("12_rxc",  32'(o_rxc), 32'd1);
        read_pulse();

        // Overrun
        send_frame(8'h11, 1'b0, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b0, 1'b1);
        check("ovr_data", 32'(o_udr_data), 32'h11);
        check("ovr_dor",  32'(o_dor), 32'd1);
        check("ovr_rxc",  32'(o_rxc), 32'd1);
        check("ovr_fe",   32'(o_fe),  32'd0);
        read_pulse();
        check("ovr_read_rxc",  32'(o_rxc), 32'd0);
        check("ovr_read_dor",  32'(o_dor), 32'd0);
        check("ovr_read_data", 32'(o_udr_data), 32'h11);

        // Receiver disabled mid-frame
        i_rxd = 1'b0;
        wait_cycles(40);
        check("rxen_busy_mid", 32'(o_busy), 32'd1);
        i_rxen = 1'b0;
        wait_cycles(1);
        check("rxen_busy_off", 32'(o_busy), 32'd0);
        wait_cycles(20);
        i_rxd = 1'b1;
        wait_cycles(c_OS);
        i_rxen = 1'b1;
        wait_cycles(c_OS);
        check("rxen_rxc",  32'(o_rxc), 32'd0);
        check("rxen_data", 32'(o_udr_data), 32'h11);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
        check("5a_data", 32'(o_udr_data), 32'h5A);
        check("5a_rxc",  32'(o_rxc), 32'd1);
        read_pulse();

        // Reset during data bit 4 of 0x7E, line held low across release
        send_bits({7'b0, 8'h7E, 1'b0}, 5);
        i_rxd = 1'b1;
        wait_cycles(8);
        i_rst_n = 1'b0;
        i_rxd   = 1'b0;
        wait_cycles(4);
        check("mid_rst_busy", 32'(o_busy), 32'd0);
        check("mid_rst_data", 32'(o_udr_data), 32'h00);
        check("mid_rst_rxc",  32'(o_rxc), 32'd0);
        i_rst_n   = 1'b1;
        seen_busy = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge i_rxclk);
            seen_busy |= o_busy;
        end
        check("held_low_no_start", 32'(seen_busy), 32'd0);
        i_rxd = 1'b1;
        wait_cycles(2 * c_OS);
        send_frame(8'h81, 1'b0, 1'b0, 1'b1);
        check("81_data", 32'(o_udr_data), 32'h81);
        check("81_rxc",  32'(o_rxc), 32'd1);
        check("81_fe",   32'(o_fe),  32'd0);
        check("81_pe",   32'(o_pe),  32'd0);
        check("81_dor",  32'(o_dor), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
